// File: rtl/fetch_line_unit.sv
// Instruction-fetch front end: one tagged burst read per cache line, a line buffer,
// and one instruction per cycle to the decoder. Optional: FETCH_HALT_ON_ZERO_EN.
module fetch_line_unit #(
  parameter int unsigned               BUS_DATA_WIDTH = 64,
  parameter int unsigned               BUS_TAG_WIDTH  = 13,
  parameter int unsigned               LINE_BEATS     = 8,
  parameter int unsigned               INSN_WIDTH     = 32,
  parameter logic [BUS_TAG_WIDTH-1:0]  READ_TAG       = 13'h1100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [63:0]                entry,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  output logic                       bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]  bus_req,
  output logic [BUS_TAG_WIDTH-1:0]   bus_reqtag,
  input  logic                       bus_reqack,
  input  logic                       bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]  bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]   bus_resptag,
  output logic                       bus_respack,
  output logic                       insn_valid,
  output logic [INSN_WIDTH-1:0]      insn,
  output logic [63:0]                insn_pc,
  input  logic                       insn_ready,
  output logic                       halt
);

  localparam int unsigned INSN_BYTES     = INSN_WIDTH / 8;
  localparam int unsigned INSNS_PER_BEAT = BUS_DATA_WIDTH / INSN_WIDTH;
  localparam int unsigned LINE_SLOTS     = LINE_BEATS * INSNS_PER_BEAT;
  localparam int unsigned LINE_BYTES     = LINE_BEATS * BUS_DATA_WIDTH / 8;
  localparam int unsigned OFF_W          = $clog2(LINE_BYTES);
  localparam int unsigned INSN_SH        = $clog2(INSN_BYTES);
  localparam int unsigned BEAT_W         = $clog2(LINE_BEATS);
  localparam int unsigned SLOT_W         = $clog2(LINE_SLOTS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN, S_HALT} state_t;

  state_t                    r_state;
  logic [63:0]               r_pc;
  logic [BEAT_W-1:0]         r_beat;
  logic                      r_discard;
  logic [BUS_DATA_WIDTH-1:0] r_line [LINE_BEATS];
  logic                      r_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] r_req;
  logic [BUS_TAG_WIDTH-1:0]  r_reqtag;
  logic                      r_insn_valid;
  logic [INSN_WIDTH-1:0]     r_insn;
  logic [63:0]               r_insn_pc;

  logic                      w_store;
  logic                      w_last_beat;
  logic                      w_accept;
  logic                      w_line_end;
  logic                      w_enter_drain;
  logic                      w_present;
  logic                      w_stop;
  logic [63:0]               w_pc_inc;
  logic [63:0]               w_sel_pc;
  logic [63:0]               w_line_addr;
  logic [SLOT_W-1:0]         w_cur_slot;
  logic [SLOT_W-1:0]         w_sel_slot;
  logic [INSN_WIDTH-1:0]     w_sel_insn;
  logic [BUS_DATA_WIDTH-1:0] w_beat_eff [LINE_BEATS];
  logic [INSN_WIDTH-1:0]     w_slots [LINE_SLOTS];
  logic                      w_unused_resptag;

  assign w_store       = (r_state == S_RESP) && bus_respcyc;
  assign w_last_beat   = w_store && (r_beat == BEAT_W'(LINE_BEATS - 1));
  assign w_accept      = (r_state == S_DRAIN) && r_insn_valid && insn_ready;
  assign w_pc_inc      = r_pc + 64'(INSN_BYTES);
  assign w_sel_pc      = w_accept ? w_pc_inc : r_pc;
  assign w_cur_slot    = r_pc[OFF_W-1:INSN_SH];
  assign w_sel_slot    = w_sel_pc[OFF_W-1:INSN_SH];
  assign w_line_end    = w_accept && (w_cur_slot == SLOT_W'(LINE_SLOTS - 1));
  assign w_line_addr   = {r_pc[63:OFF_W], {OFF_W{1'b0}}};
  assign w_enter_drain = w_last_beat && !r_discard && !redirect_valid;
  assign w_present     = w_enter_drain || (w_accept && !w_line_end && !redirect_valid);
  assign w_sel_insn    = w_slots[w_sel_slot];
  assign w_unused_resptag = ^bus_resptag;

  // The beat arriving this cycle is forwarded so the first slot can be presented right away.
  for (genvar b = 0; b < LINE_BEATS; b++) begin : g_beat
    assign w_beat_eff[b] = (w_store && (r_beat == BEAT_W'(b))) ? bus_resp : r_line[b];
    for (genvar s = 0; s < INSNS_PER_BEAT; s++) begin : g_slot
      assign w_slots[b*INSNS_PER_BEAT + s] = w_beat_eff[b][s*INSN_WIDTH +: INSN_WIDTH];
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  logic r_halt;
  assign w_stop = (w_sel_insn == '0);
  assign halt   = r_halt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_halt <= 1'b0;
    else if (redirect_valid)       r_halt <= 1'b0;
    else if (w_present && w_stop)  r_halt <= 1'b1;
  end
`else
  assign w_stop = 1'b0;
  assign halt   = 1'b0;
`endif

  // Line buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LINE_BEATS); i++) r_line[i] <= '0;
    end else if (w_store) begin
      r_line[r_beat] <= bus_resp;
    end
  end

  // Fetch FSM with registered bus-request and decoder outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= entry;
      r_beat       <= '0;
      r_discard    <= 1'b0;
      r_reqcyc     <= 1'b0;
      r_req        <= '0;
      r_reqtag     <= '0;
      r_insn_valid <= 1'b0;
      r_insn       <= '0;
      r_insn_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end else begin
            r_state  <= S_REQ;
            r_reqcyc <= 1'b1;
            r_req    <= BUS_DATA_WIDTH'(w_line_addr);
            r_reqtag <= READ_TAG;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            r_pc      <= redirect_pc;
            r_discard <= 1'b1;
          end
          if (bus_reqack) begin
            r_state  <= S_RESP;
            r_reqcyc <= 1'b0;
            r_req    <= '0;
            r_reqtag <= '0;
            r_beat   <= '0;
          end
        end
        S_RESP: begin
          if (redirect_valid) begin
            r_pc      <= redirect_pc;
            r_discard <= 1'b1;
          end
          if (w_store) r_beat <= r_beat + BEAT_W'(1);
          if (w_last_beat) begin
            r_discard <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (redirect_valid) begin
            r_pc         <= redirect_pc;
            r_state      <= S_IDLE;
            r_insn_valid <= 1'b0;
          end else if (w_accept) begin
            r_pc <= w_pc_inc;
            if (w_line_end) begin
              r_state      <= S_IDLE;
              r_insn_valid <= 1'b0;
            end
          end
        end
        S_HALT: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Present the slot at the post-update pc, or stop on a zero instruction
      if (w_present) begin
        if (w_stop) begin
          r_state      <= S_HALT;
          r_insn_valid <= 1'b0;
        end else begin
          r_state      <= S_DRAIN;
          r_insn_valid <= 1'b1;
          r_insn       <= w_sel_insn;
          r_insn_pc    <= w_sel_pc;
        end
      end
    end
  end

  assign bus_reqcyc  = r_reqcyc;
  assign bus_req     = r_req;
  assign bus_reqtag  = r_reqtag;
  assign bus_respack = w_store;
  assign insn_valid  = r_insn_valid;
  assign insn        = r_insn;
  assign insn_pc     = r_insn_pc;

endmodule

// File: doc/fetch_line_unit.md
# fetch_line_unit

Parametrised instruction-fetch front end: issues one tagged burst read per cache-line-sized block over the Sysbus request/response channels, assembles the returned beats into a line buffer, and presents instructions one at a time to the decoder over a valid/ready handshake. It supports mid-line entry points, sequential line-to-line fetch, and PC redirects that arrive mid-burst. It sits between the Sysbus port of `top` and the decoder.

## Interface
- BUS_DATA_WIDTH, 64, bus beat width in bits
- BUS_TAG_WIDTH, 13, bus tag width
- LINE_BEATS, 8, beats per burst (power of two, ≥2)
- INSN_WIDTH, 32, instruction width; must divide BUS_DATA_WIDTH
- READ_TAG, 13'h1100, tag driven on read requests
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- entry  in  64  PC loaded at reset
- redirect_valid  in  1  replace fetch PC this cycle
- redirect_pc  in  64  new PC; INSN_WIDTH/8-aligned
- bus_reqcyc  out  1  request valid
- bus_req  out  BUS_DATA_WIDTH  line-aligned request address
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_reqack  in  1  request accepted
- bus_respcyc  in  1  response beat valid
- bus_resp  in  BUS_DATA_WIDTH  response beat
- bus_resptag  in  BUS_TAG_WIDTH  response tag (ignored)
- bus_respack  out  1  beat acknowledge
- insn_valid  out  1  instruction available
- insn  out  INSN_WIDTH  instruction
- insn_pc  out  64  address of insn
- insn_ready  in  1  decoder accepts insn
- halt  out  1  fetch stopped on zero instruction (sticky)

## Operation
- LINE_BYTES = LINE_BEATS·BUS_DATA_WIDTH/8; line address = pc with low log2(LINE_BYTES) bits cleared.
- States: IDLE, REQ, RESP, DRAIN, HALT.
- IDLE → REQ unconditionally, and latches the line address from pc.
- REQ: bus_reqcyc=1, bus_req=line address, bus_reqtag=READ_TAG, all held stable until bus_reqack=1, then → RESP. A request is never withdrawn.
- RESP: each cycle with bus_respcyc=1 stores bus_resp at beat index (0..LINE_BEATS-1) and raises bus_respack combinationally in the same cycle. Gaps in respcyc are stalls. When the LINE_BEATS-th beat is stored → DRAIN.
- DRAIN: insn = line slot selected by pc offset; within a beat, the lower INSN_WIDTH bits come first (little-endian). On insn_valid & insn_ready, pc += INSN_WIDTH/8 (mod 2^64). When the slot past the last slot is reached → IDLE, which fetches the next sequential line.
- Entry/redirect to a mid-line pc: emission starts at that slot, and earlier slots are skipped.
- Redirect in IDLE/DRAIN/HALT: pc ← redirect_pc, → IDLE next cycle, halt cleared. If insn_ready is asserted in the same cycle, the redirect wins and that instruction counts as not consumed.
- Redirect in REQ/RESP: pc ← redirect_pc and a discard flag is set. The burst completes (all beats acked, data dropped), then → IDLE. A later redirect overwrites pc.
- bus_resptag is not checked, because only one read is outstanding at a time.

## Timing
- Reset values: bus_reqcyc 0, bus_req 0, bus_reqtag 0, bus_respack 0, insn_valid 0, insn 0, insn_pc 0, halt 0; state IDLE; pc = entry.
- Reset release → bus_reqcyc high on the 2nd rising edge (IDLE for one cycle, then REQ).
- bus_req and bus_reqtag are 0 whenever bus_reqcyc=0.
- The first insn_valid is one cycle after the last beat is stored.
- Sustained throughput is one instruction per cycle while insn_ready=1.
- Line end → next bus_reqcyc: 2 cycles.
- insn_valid is high only in DRAIN and drops the cycle after a redirect.
- Reset asserted mid-burst: all outputs return to their reset values immediately. The bus is not drained; the interconnect is reset together with this block.

## Configuration
- FETCH_HALT_ON_ZERO_EN defined: an all-zero instruction reached in DRAIN is not presented (insn_valid=0). The block enters HALT, asserts halt, and issues no further bus requests; only a redirect or reset leaves HALT.
- Not defined: zero instructions pass through as ordinary instructions, halt is tied 0, and HALT is unreachable.

## Test plan
- Entry 0x1000, memory returns beats 0x1..0x8 with no gaps → bus_req=0x1000 with tag 0x1100, 16 instructions in order (0x1, 0x0, 0x2, 0x0, …), insn_pc 0x1000..0x103C, then bus_req=0x1040.
- Entry 0x1038 → one request to 0x1000; only slots 14 and 15 emitted (pc 0x1038, 0x103C); next request 0x1040.
- reqack delayed 5 cycles, respcyc with 1-cycle gaps between beats → request held stable for all 5 cycles; each beat acked once; line assembled correctly.
- Redirect to 0x2000 during beat 3 of a burst → remaining beats acked, no insn_valid from the dropped line, next bus_req=0x2000.
- insn_ready toggling every other cycle together with a redirect in DRAIN → no instruction duplicated or skipped; the instruction presented in the redirect cycle is not consumed.
- With FETCH_HALT_ON_ZERO_EN, a zero at slot 5 → 5 instructions emitted, halt=1, no bus_reqcyc for 100 cycles; a redirect clears halt and starts a fetch.
